stage_mem: RTL and testbench
============================

# stage_mem

Memory-access stage of the five-stage core, between execute and write-back. Accepts one instruction per cycle from execute and performs loads/stores over a Wishbone B4 classic data port with sign/zero extension and byte-lane steering. Detects load/store misalignment and bus errors. Registers the result into the MEM/WB pipeline register that feeds `stage_wb`.

## Interface
Parameters:
- none (XLEN fixed at 32)

Ports:
- `clk_i` in 1: clock; all state updates on rising edge
- `rst_i` in 1: reset, synchronous, active-low
- `valid_i` in 1: execute presents an instruction this cycle
- `flush_i` in 1: exception taken in WB (`is_exc_taken`); squash the current instruction
- `pc_i`, `instruction_i` in 32: pass-through
- `alu_d_i` in 32: ALU result; effective address for loads/stores
- `st_d_i` in 32: rs2 store data
- `funct3_i` in 3: access size/sign (000 B, 001 H, 010 W, 100 BU, 101 HU)
- `is_ld_mem_i`, `is_st_mem_i` in 1: load / store
- `ctrl_i` in 6: {is_op, is_lui, is_auipc, is_system, is_jal, is_jalr}, pass-through
- `e_illegal_inst_i`, `e_inst_addr_mis_i` in 1: upstream exceptions, pass-through
- `stall_o` out 1: hold execute and earlier stages
- `valid_o` out 1: MEM/WB register holds a live instruction
- `pc_o`, `instruction_o`, `alu_d_o` out 32; `funct3_o` out 3; `ctrl_o` out 6; `is_ld_mem_o` out 1: registered pass-through
- `mem_d_o` out 32: extended load data
- `mem_addr_o` out 32: effective address
- `e_illegal_inst_o`, `e_inst_addr_mis_o`, `e_ld_addr_mis_o`, `e_st_addr_mis_o`, `e_ld_fault_o`, `e_st_fault_o` out 1
- `dwbm_addr_o` out 32 (word-aligned), `dwbm_dat_o` out 32, `dwbm_sel_o` out 4, `dwbm_cyc_o`/`dwbm_stb_o`/`dwbm_we_o` out 1
- `dwbm_dat_i` in 32, `dwbm_ack_i` in 1, `dwbm_err_i` in 1

## Operation
- `mem_req` = `valid_i` & (`is_ld_mem_i` | `is_st_mem_i`) & !misaligned & !`e_illegal_inst_i` & !`e_inst_addr_mis_i` & !`flush_i`.
- Misaligned: H/HU with addr[0]=1; W with addr[1:0]≠0. No bus cycle is issued. `e_ld_addr_mis_o` or `e_st_addr_mis_o` is set, and `mem_addr_o` = faulting address.
- FSM states:
  - IDLE: if `mem_req`, latch address/data/sel/we and go to REQ.
  - REQ: drive `cyc`=`stb`=1. On `ack` or `err`, go to IDLE and load the MEM/WB register. If both are high, `err` wins.
- Store steering:
  - B: data byte replicated to all 4 lanes, `sel` = 1<<addr[1:0].
  - H: halfword replicated to both halves, `sel` = addr[1] ? 1100 : 0011.
  - W: `sel` = 1111.
- Loads use `sel` per size as for stores. Lane selected by addr[1:0]. B/H are sign-extended; BU/HU are zero-extended.
- `err` terminates the cycle, sets `e_ld_fault_o`/`e_st_fault_o`, and forces `mem_d_o` = 0.
- Non-memory instructions, misaligned accesses, and upstream-excepted instructions pass to MEM/WB in one cycle without stalling.
- When `valid_o`=0, all `ctrl_o`, `is_ld_mem_o` and `e_*_o` are 0, so WB writes nothing and takes no exception.
- `flush_i`:
  - In IDLE: the presented instruction is dropped and `valid_o`=0 next cycle; no bus cycle.
  - In REQ: the bus cycle runs to completion. Its result is discarded (`valid_o`=0). `flush_i` is not sticky: it is latched into a drop flag while in REQ.

## Timing
- `stall_o` (combinational) = (IDLE & `mem_req`) | (REQ & !`ack` & !`err`).
- Zero-wait load:
  - Cycle 0: presented.
  - Cycle 1: `cyc`/`stb` high, `ack` high.
  - Cycle 2: `valid_o`=1 with `mem_d_o`.
  - Each wait state adds one cycle.
- Non-memory instruction: `valid_o` one cycle after presentation.
- Back-to-back memory ops: `cyc` drops for at least one cycle (IDLE) between accesses. Two zero-wait ops complete at cycles 2 and 4.
- `stall_o`=0 in the ack cycle, so execute advances while MEM/WB captures.
- Reset (`rst_i`=0 at a rising edge): state IDLE, `cyc`/`stb`/`we`=0, `sel`=0, `valid_o`=0, all data outputs and `e_*_o` = 0. Mid-cycle reset drops `cyc` on the next edge and ignores a late `ack`.

## Test plan
- LBU addr 0x103, bus word 0x80FF7F01 (`ack` same cycle) -> `sel`=1000, `mem_d_o`=0x00000080, `valid_o` at cycle 2. Repeat with LB -> 0xFFFFFF80.
- SH addr 0x102, rs2=0x1234ABCD -> `dwbm_dat_o`=0xABCDABCD, `sel`=1100, `we`=1, addr 0x100. 3 wait states -> `stall_o` high for 4 cycles.
- LW addr 0x202 -> no `cyc`; `e_ld_addr_mis_o`=1, `mem_addr_o`=0x202, `valid_o` next cycle, `stall_o` never high.
- SW with `err` on first cycle -> `e_st_fault_o`=1, `mem_d_o`=0, FSM back to IDLE.
- `flush_i` with LW presented -> no bus cycle, `valid_o`=0. `flush_i` during REQ -> cycle completes, `valid_o`=0.
- `rst_i` low during REQ with `ack` pending -> `cyc`=0 next edge, all outputs 0, next LW completes normally.

Source files
------------

// File: rtl/stage_mem.sv
// Memory-access stage: issues Wishbone B4 classic loads/stores with byte-lane steering
// and sign/zero extension, and registers the result into the MEM/WB pipeline register.
module stage_mem (
  input  logic        clk_i,
  input  logic        rst_i,
  input  logic        valid_i,
  input  logic        flush_i,
  input  logic [31:0] pc_i,
  input  logic [31:0] instruction_i,
  input  logic [31:0] alu_d_i,
  input  logic [31:0] st_d_i,
  input  logic [2:0]  funct3_i,
  input  logic        is_ld_mem_i,
  input  logic        is_st_mem_i,
  input  logic [5:0]  ctrl_i,
  input  logic        e_illegal_inst_i,
  input  logic        e_inst_addr_mis_i,
  output logic        stall_o,
  output logic        valid_o,
  output logic [31:0] pc_o,
  output logic [31:0] instruction_o,
  output logic [31:0] alu_d_o,
  output logic [2:0]  funct3_o,
  output logic [5:0]  ctrl_o,
  output logic        is_ld_mem_o,
  output logic [31:0] mem_d_o,
  output logic [31:0] mem_addr_o,
  output logic        e_illegal_inst_o,
  output logic        e_inst_addr_mis_o,
  output logic        e_ld_addr_mis_o,
  output logic        e_st_addr_mis_o,
  output logic        e_ld_fault_o,
  output logic        e_st_fault_o,
  output logic [31:0] dwbm_addr_o,
  output logic [31:0] dwbm_dat_o,
  output logic [3:0]  dwbm_sel_o,
  output logic        dwbm_cyc_o,
  output logic        dwbm_stb_o,
  output logic        dwbm_we_o,
  input  logic [31:0] dwbm_dat_i,
  input  logic        dwbm_ack_i,
  input  logic        dwbm_err_i
);

  typedef enum logic {S_IDLE, S_REQ} state_e;

  function automatic logic [3:0] lane_sel(input logic [2:0] f3, input logic [1:0] a);
    if (f3[1])      lane_sel = 4'b1111;
    else if (f3[0]) lane_sel = a[1] ? 4'b1100 : 4'b0011;
    else            lane_sel = 4'b0001 << a;
  endfunction

  function automatic logic [31:0] store_steer(input logic [2:0] f3, input logic [31:0] d);
    if (f3[1])      store_steer = d;
    else if (f3[0]) store_steer = {2{d[15:0]}};
    else            store_steer = {4{d[7:0]}};
  endfunction

  function automatic logic [31:0] load_ext(input logic [2:0] f3, input logic [1:0] a,
                                           input logic [31:0] w);
    logic [7:0]  b;
    logic [15:0] h;
    b = w[{a, 3'b000} +: 8];
    h = a[1] ? w[31:16] : w[15:0];
    case (f3)
      3'b000:  load_ext = {{24{b[7]}}, b};
      3'b100:  load_ext = {24'b0, b};
      3'b001:  load_ext = {{16{h[15]}}, h};
      3'b101:  load_ext = {16'b0, h};
      default: load_ext = w;
    endcase
  endfunction

  state_e      state_q, state_d;
  logic [31:0] pc_q, pc_d, inst_q, inst_d, addr_q, addr_d, wdat_q, wdat_d;
  logic [3:0]  sel_q, sel_d;
  logic [2:0]  f3_q, f3_d;
  logic [5:0]  ctrl_q, ctrl_d;
  logic        we_q, we_d, ld_q, ld_d, drop_q, drop_d;

  logic        wb_vld_q, wb_vld_d;
  logic [31:0] wb_pc_q, wb_pc_d, wb_inst_q, wb_inst_d, wb_alu_q, wb_alu_d;
  logic [31:0] wb_memd_q, wb_memd_d;
  logic [2:0]  wb_f3_q, wb_f3_d;
  logic [5:0]  wb_ctrl_q, wb_ctrl_d;
  logic        wb_ld_q, wb_ld_d;
  logic [5:0]  wb_exc_q, wb_exc_d;

  logic misaligned, mem_req, bus_done, drop_now;

  always_comb begin
    misaligned = (funct3_i[1] && (alu_d_i[1:0] != 2'b00)) ||
                 (!funct3_i[1] && funct3_i[0] && alu_d_i[0]);
    mem_req    = valid_i && (is_ld_mem_i || is_st_mem_i) && !misaligned &&
                 !e_illegal_inst_i && !e_inst_addr_mis_i && !flush_i;
    bus_done   = dwbm_ack_i || dwbm_err_i;
    drop_now   = drop_q || flush_i;
    stall_o    = ((state_q == S_IDLE) && mem_req) || ((state_q == S_REQ) && !bus_done);
  end

  always_comb begin
    state_d   = state_q;
    pc_d      = pc_q;
    inst_d    = inst_q;
    addr_d    = addr_q;
    wdat_d    = wdat_q;
    sel_d     = sel_q;
    we_d      = we_q;
    f3_d      = f3_q;
    ctrl_d    = ctrl_q;
    ld_d      = ld_q;
    drop_d    = drop_q;
    // MEM/WB register is reloaded every cycle; a bubble clears every field
    wb_vld_d  = 1'b0;
    wb_pc_d   = '0;
    wb_inst_d = '0;
    wb_alu_d  = '0;
    wb_memd_d = '0;
    wb_f3_d   = '0;
    wb_ctrl_d = '0;
    wb_ld_d   = 1'b0;
    wb_exc_d  = '0;
    unique case (state_q)
      S_IDLE: begin
        if (mem_req) begin
          state_d = S_REQ;
          pc_d    = pc_i;
          inst_d  = instruction_i;
          addr_d  = alu_d_i;
          wdat_d  = is_st_mem_i ? store_steer(funct3_i, st_d_i) : '0;
          sel_d   = lane_sel(funct3_i, alu_d_i[1:0]);
          we_d    = is_st_mem_i;
          f3_d    = funct3_i;
          ctrl_d  = ctrl_i;
          ld_d    = is_ld_mem_i;
          drop_d  = 1'b0;
        end else if (valid_i && !flush_i) begin
          wb_vld_d  = 1'b1;
          wb_pc_d   = pc_i;
          wb_inst_d = instruction_i;
          wb_alu_d  = alu_d_i;
          wb_f3_d   = funct3_i;
          wb_ctrl_d = ctrl_i;
          wb_ld_d   = is_ld_mem_i;
          // {illegal, inst_mis, ld_mis, st_mis, ld_fault, st_fault}
          wb_exc_d  = {e_illegal_inst_i, e_inst_addr_mis_i,
                       is_ld_mem_i && misaligned, is_st_mem_i && misaligned, 2'b00};
        end
      end
      S_REQ: begin
        drop_d = drop_now;
        if (bus_done) begin
          state_d = S_IDLE;
          sel_d   = '0;
          we_d    = 1'b0;
          if (!drop_now) begin
            wb_vld_d  = 1'b1;
            wb_pc_d   = pc_q;
            wb_inst_d = inst_q;
            wb_alu_d  = addr_q;
            wb_f3_d   = f3_q;
            wb_ctrl_d = ctrl_q;
            wb_ld_d   = ld_q;
            wb_memd_d = (dwbm_err_i || we_q) ? 32'h0 : load_ext(f3_q, addr_q[1:0], dwbm_dat_i);
            wb_exc_d  = {4'b0000, dwbm_err_i && !we_q, dwbm_err_i && we_q};
          end
        end
      end
      default: state_d = S_IDLE;
    endcase
  end

  always_ff @(posedge clk_i) begin
    if (!rst_i) begin
      state_q   <= S_IDLE;
      pc_q      <= '0;
      inst_q    <= '0;
      addr_q    <= '0;
      wdat_q    <= '0;
      sel_q     <= '0;
      we_q      <= 1'b0;
      f3_q      <= '0;
      ctrl_q    <= '0;
      ld_q      <= 1'b0;
      drop_q    <= 1'b0;
      wb_vld_q  <= 1'b0;
      wb_pc_q   <= '0;
      wb_inst_q <= '0;
      wb_alu_q  <= '0;
      wb_memd_q <= '0;
      wb_f3_q   <= '0;
      wb_ctrl_q <= '0;
      wb_ld_q   <= 1'b0;
      wb_exc_q  <= '0;
    end else begin
      state_q   <= state_d;
      pc_q      <= pc_d;
      inst_q    <= inst_d;
      addr_q    <= addr_d;
      wdat_q    <= wdat_d;
      sel_q     <= sel_d;
      we_q      <= we_d;
      f3_q      <= f3_d;
      ctrl_q    <= ctrl_d;
      ld_q      <= ld_d;
      drop_q    <= drop_d;
      wb_vld_q  <= wb_vld_d;
      wb_pc_q   <= wb_pc_d;
      wb_inst_q <= wb_inst_d;
      wb_alu_q  <= wb_alu_d;
      wb_memd_q <= wb_memd_d;
      wb_f3_q   <= wb_f3_d;
      wb_ctrl_q <= wb_ctrl_d;
      wb_ld_q   <= wb_ld_d;
      wb_exc_q  <= wb_exc_d;
    end
  end

  assign valid_o           = wb_vld_q;
  assign pc_o              = wb_pc_q;
  assign instruction_o     = wb_inst_q;
  assign alu_d_o           = wb_alu_q;
  assign mem_addr_o        = wb_alu_q;
  assign funct3_o          = wb_f3_q;
  assign ctrl_o            = wb_ctrl_q;
  assign is_ld_mem_o       = wb_ld_q;
  assign mem_d_o           = wb_memd_q;
  assign e_illegal_inst_o  = wb_exc_q[5];
  assign e_inst_addr_mis_o = wb_exc_q[4];
  assign e_ld_addr_mis_o   = wb_exc_q[3];
  assign e_st_addr_mis_o   = wb_exc_q[2];
  assign e_ld_fault_o      = wb_exc_q[1];
  assign e_st_fault_o      = wb_exc_q[0];

  assign dwbm_addr_o = {addr_q[31:2], 2'b00};
  assign dwbm_dat_o  = wdat_q;
  assign dwbm_sel_o  = sel_q;
  assign dwbm_we_o   = we_q;
  assign dwbm_cyc_o  = (state_q == S_REQ);
  assign dwbm_stb_o  = (state_q == S_REQ);

endmodule

// File: tb/tb_stage_mem.sv
// Randomised scoreboard bench for stage_mem: a driver pushes model results, a monitor
// pops them whenever valid_o is high, and a Wishbone slave checks each bus cycle.
module tb_stage_mem;

  logic        clk, rst_i, valid_i, flush_i;
  logic [31:0] pc_i, instruction_i, alu_d_i, st_d_i;
  logic [2:0]  funct3_i;
  logic        is_ld_mem_i, is_st_mem_i;
  logic [5:0]  ctrl_i;
  logic        e_illegal_inst_i, e_inst_addr_mis_i;
  logic        stall_o, valid_o;
  logic [31:0] pc_o, instruction_o, alu_d_o;
  logic [2:0]  funct3_o;
  logic [5:0]  ctrl_o;
  logic        is_ld_mem_o;
  logic [31:0] mem_d_o, mem_addr_o;
  logic        e_illegal_inst_o, e_inst_addr_mis_o, e_ld_addr_mis_o, e_st_addr_mis_o;
  logic        e_ld_fault_o, e_st_fault_o;
  logic [31:0] dwbm_addr_o, dwbm_dat_o, dwbm_dat_i;
  logic [3:0]  dwbm_sel_o;
  logic        dwbm_cyc_o, dwbm_stb_o, dwbm_we_o, dwbm_ack_i, dwbm_err_i;

  stage_mem dut (
    .clk_i(clk), .rst_i(rst_i), .valid_i(valid_i), .flush_i(flush_i),
    .pc_i(pc_i), .instruction_i(instruction_i), .alu_d_i(alu_d_i), .st_d_i(st_d_i),
    .funct3_i(funct3_i), .is_ld_mem_i(is_ld_mem_i), .is_st_mem_i(is_st_mem_i),
    .ctrl_i(ctrl_i), .e_illegal_inst_i(e_illegal_inst_i), .e_inst_addr_mis_i(e_inst_addr_mis_i),
    .stall_o(stall_o), .valid_o(valid_o), .pc_o(pc_o), .instruction_o(instruction_o),
    .alu_d_o(alu_d_o), .funct3_o(funct3_o), .ctrl_o(ctrl_o), .is_ld_mem_o(is_ld_mem_o),
    .mem_d_o(mem_d_o), .mem_addr_o(mem_addr_o),
    .e_illegal_inst_o(e_illegal_inst_o), .e_inst_addr_mis_o(e_inst_addr_mis_o),
    .e_ld_addr_mis_o(e_ld_addr_mis_o), .e_st_addr_mis_o(e_st_addr_mis_o),
    .e_ld_fault_o(e_ld_fault_o), .e_st_fault_o(e_st_fault_o),
    .dwbm_addr_o(dwbm_addr_o), .dwbm_dat_o(dwbm_dat_o), .dwbm_sel_o(dwbm_sel_o),
    .dwbm_cyc_o(dwbm_cyc_o), .dwbm_stb_o(dwbm_stb_o), .dwbm_we_o(dwbm_we_o),
    .dwbm_dat_i(dwbm_dat_i), .dwbm_ack_i(dwbm_ack_i), .dwbm_err_i(dwbm_err_i)
  );

  typedef struct packed {
    logic [31:0] pc, inst, alu;
    logic [2:0]  f3;
    logic [5:0]  ctrl;
    logic        ld;
    logic [31:0] mem_d, mem_addr;
    logic        ill, iam, ldmis, stmis, ldf, stf;
  } out_t;

  typedef struct {
    logic [31:0] pc, inst, addr, sd, rdata;
    logic [2:0]  f3;
    logic        ld, st, ill, iam;
    logic [5:0]  ctrl;
    int          waits;
    bit          err, both, flush_idle, flush_mid;
  } txn_t;

  int unsigned total = 0, passed = 0, cycle_cnt = 0;
  out_t        exp_q[$];
  int unsigned cyc_q[$];

  // Bus plan for the transaction currently presented
  bit          plan_bus, plan_err, plan_both, plan_we;
  int          plan_wait;
  logic [31:0] plan_rdata, plan_addr, plan_wdat;
  logic [3:0]  plan_sel;

  initial clk = 1'b0;
  always #5 clk = ~clk;
  always @(posedge clk) cycle_cnt <= cycle_cnt + 1;

  task automatic check(input string name, input logic [191:0] got, input logic [191:0] want);
    total++;
    if (got === want) passed++;
    else $display("FAIL %s got=%0h want=%0h", name, got, want);
  endtask

  task automatic finish_up();
    $display("%0d/%0d checks passed", passed, total);
    $finish;
  endtask

  initial begin
    #400000;
    $display("FAIL watchdog got=timeout want=finish");
    $fatal(1, "watchdog");
  end

  // Monitor
  initial begin
    out_t got, want;
    int unsigned c;
    forever begin
      @(negedge clk);
      if (valid_o) begin
        got = '{pc: pc_o, inst: instruction_o, alu: alu_d_o, f3: funct3_o, ctrl: ctrl_o,
                ld: is_ld_mem_o, mem_d: mem_d_o, mem_addr: mem_addr_o,
                ill: e_illegal_inst_o, iam: e_inst_addr_mis_o, ldmis: e_ld_addr_mis_o,
                stmis: e_st_addr_mis_o, ldf: e_ld_fault_o, stf: e_st_fault_o};
        if (exp_q.size() == 0) check("unexpected_valid", 1, 0);
        else begin
          want = exp_q.pop_front();
          c = cyc_q.pop_front();
          check("wb_record", got, want);
          check("wb_cycle", cycle_cnt, c);
        end
      end else begin
        check("bubble_clean", {ctrl_o, is_ld_mem_o, e_illegal_inst_o, e_inst_addr_mis_o,
              e_ld_addr_mis_o, e_st_addr_mis_o, e_ld_fault_o, e_st_fault_o}, 0);
      end
    end
  end

  // Wishbone slave
  initial begin
    int cnt;
    cnt = 0;
    dwbm_ack_i = 0; dwbm_err_i = 0; dwbm_dat_i = 0;
    forever begin
      @(posedge clk); #1;
      if (dwbm_cyc_o && dwbm_stb_o) begin
        if (cnt == 0 && !plan_bus) check("unexpected_cyc", 1, 0);
        if (cnt == plan_wait) begin
          dwbm_err_i = plan_err;
          dwbm_ack_i = !plan_err || plan_both;
          dwbm_dat_i = plan_rdata;
          check("bus_addr", dwbm_addr_o, plan_addr);
          check("bus_sel", dwbm_sel_o, plan_sel);
          check("bus_we", dwbm_we_o, plan_we);
          if (plan_we) check("bus_wdat", dwbm_dat_o, plan_wdat);
        end else begin
          dwbm_ack_i = 0; dwbm_err_i = 0; dwbm_dat_i = $urandom;
        end
        cnt++;
      end else begin
        dwbm_ack_i = 0; dwbm_err_i = 0; cnt = 0;
      end
    end
  end

  function automatic txn_t mk(input logic ld, input logic st, input logic [2:0] f3,
                              input logic [31:0] addr, input logic [31:0] sd,
                              input logic [31:0] rdata, input int waits, input bit err);
    txn_t t;
    t.pc = $urandom; t.inst = $urandom; t.addr = addr; t.sd = sd; t.rdata = rdata;
    t.f3 = f3; t.ld = ld; t.st = st; t.ill = 0; t.iam = 0; t.ctrl = 6'd0;
    t.waits = waits; t.err = err; t.both = 0; t.flush_idle = 0; t.flush_mid = 0;
    return t;
  endfunction

  task automatic set_plan(input txn_t t, output bit req, output out_t e);
    int size, lane;
    bit mis;
    logic [31:0] w, v;
    size = t.f3[1] ? 4 : (t.f3[0] ? 2 : 1);
    lane = int'(t.addr % 4);
    mis  = (t.ld || t.st) && (t.addr % size != 0);
    req  = (t.ld || t.st) && !mis && !t.ill && !t.iam && !t.flush_idle;
    plan_bus = req; plan_wait = t.waits; plan_err = t.err; plan_both = t.both;
    plan_rdata = t.rdata; plan_addr = t.addr - lane; plan_we = t.st;
    if (size == 4)      begin plan_sel = 4'hF; plan_wdat = t.sd; end
    else if (size == 2) begin plan_sel = 4'(3 << lane); plan_wdat = (t.sd & 32'hFFFF) * 32'h00010001; end
    else                begin plan_sel = 4'(1 << lane); plan_wdat = (t.sd & 32'hFF) * 32'h01010101; end
    w = t.rdata >> (8 * lane);
    case (t.f3)
      3'b000:  begin v = w & 32'hFF;   if (v >= 128)   v = v - 256;   end
      3'b100:  v = w & 32'hFF;
      3'b001:  begin v = w & 32'hFFFF; if (v >= 32768) v = v - 65536; end
      3'b101:  v = w & 32'hFFFF;
      default: v = t.rdata;
    endcase
    e = '0;
    e.pc = t.pc; e.inst = t.inst; e.alu = t.addr; e.f3 = t.f3; e.ctrl = t.ctrl;
    e.ld = t.ld; e.mem_addr = t.addr;
    if (req) begin
      e.mem_d = (t.err || t.st) ? 32'h0 : v;
      e.ldf = t.err && t.ld; e.stf = t.err && t.st;
    end else begin
      e.ill = t.ill; e.iam = t.iam; e.ldmis = t.ld && mis; e.stmis = t.st && mis;
    end
  endtask

  task automatic present(input txn_t t);
    valid_i = 1; pc_i = t.pc; instruction_i = t.inst; alu_d_i = t.addr; st_d_i = t.sd;
    funct3_i = t.f3; is_ld_mem_i = t.ld; is_st_mem_i = t.st; ctrl_i = t.ctrl;
    e_illegal_inst_i = t.ill; e_inst_addr_mis_i = t.iam;
  endtask

  // Called at posedge+1; returns at posedge+1 of the cycle after acceptance
  task automatic send(input txn_t t);
    bit req, done;
    out_t e;
    int n, done_cyc;
    set_plan(t, req, e);
    present(t);
    flush_i = t.flush_idle;
    n = 0; done = 0; done_cyc = 0;
    while (!done) begin
      @(negedge clk);
      if (!stall_o) begin done = 1; done_cyc = int'(cycle_cnt); end
      else n++;
      @(posedge clk); #1;
      flush_i = (t.flush_mid && n == 1 && !done);
      if (n > 40) begin
        check("stall_timeout", n, req ? 1 + t.waits : 0);
        finish_up();
      end
    end
    check("stall_cycles", n, req ? 1 + t.waits : 0);
    if (!t.flush_idle && !(req && t.flush_mid)) begin
      exp_q.push_back(e);
      cyc_q.push_back(done_cyc + 1);
    end
    valid_i = 0; flush_i = 0;
  endtask

  initial begin
    txn_t t;
    bit req;
    out_t e;
    logic [2:0] ldf3[5] = '{3'b000, 3'b001, 3'b010, 3'b100, 3'b101};
    int kind, size;

    rst_i = 0; valid_i = 0; flush_i = 0; pc_i = 0; instruction_i = 0; alu_d_i = 0;
    st_d_i = 0; funct3_i = 0; is_ld_mem_i = 0; is_st_mem_i = 0; ctrl_i = 0;
    e_illegal_inst_i = 0; e_inst_addr_mis_i = 0;
    plan_bus = 0; plan_wait = 0; plan_err = 0; plan_both = 0; plan_we = 0;
    plan_rdata = 0; plan_addr = 0; plan_wdat = 0; plan_sel = 0;
    repeat (3) @(negedge clk);
    check("reset_valid", valid_o, 0);
    check("reset_bus", {dwbm_cyc_o, dwbm_stb_o, dwbm_we_o, dwbm_sel_o}, 0);
    check("reset_data", {pc_o, instruction_o, alu_d_o, mem_d_o, mem_addr_o, dwbm_addr_o, dwbm_dat_o}, 0);
    check("reset_stall", stall_o, 0);
    @(posedge clk); #1;
    rst_i = 1;

    // LBU / LB from lane 3
    send(mk(1, 0, 3'b100, 32'h103, 0, 32'h80FF7F01, 0, 0));
    send(mk(1, 0, 3'b000, 32'h103, 0, 32'h80FF7F01, 0, 0));
    // SH upper half, 3 wait states
    send(mk(0, 1, 3'b001, 32'h102, 32'h1234ABCD, 0, 3, 0));
    // misaligned LW
    send(mk(1, 0, 3'b010, 32'h202, 0, 0, 0, 0));
    // SW bus error
    send(mk(0, 1, 3'b010, 32'h400, 32'hDEADBEEF, 0, 0, 1));
    // flush in IDLE, then flush during REQ
    t = mk(1, 0, 3'b010, 32'h500, 0, 32'h11223344, 0, 0); t.flush_idle = 1; send(t);
    t = mk(1, 0, 3'b010, 32'h504, 0, 32'h55667788, 2, 0); t.flush_mid = 1; send(t);
    // non-memory instruction
    t = mk(0, 0, 3'b111, 32'hCAFE0001, 0, 0, 0, 0); t.ctrl = 6'b100000; send(t);
    // err and ack together: err wins
    t = mk(1, 0, 3'b001, 32'h602, 0, 32'h8001FFFF, 1, 1); t.both = 1; send(t);

    // reset while REQ with ack in flight
    t = mk(1, 0, 3'b010, 32'h300, 0, 32'hA5A5A5A5, 0, 0);
    set_plan(t, req, e);
    present(t);
    @(negedge clk);
    check("rstreq_stall", stall_o, 1);
    @(posedge clk); #1;
    rst_i = 0; valid_i = 0;
    @(negedge clk);
    check("rstreq_cyc_before", dwbm_cyc_o, 1);
    @(posedge clk); #1;
    rst_i = 1;
    @(negedge clk);
    check("rstreq_cyc_after", {dwbm_cyc_o, dwbm_stb_o, dwbm_we_o, dwbm_sel_o}, 0);
    check("rstreq_outputs", {valid_o, mem_d_o, pc_o, alu_d_o}, 0);
    @(posedge clk); #1;
    send(mk(1, 0, 3'b010, 32'h700, 0, 32'h0BADF00D, 1, 0));

    for (int i = 0; i < 300; i++) begin
      kind = $urandom_range(0, 2);
      if (kind == 1)      t = mk(1, 0, ldf3[$urandom_range(0, 4)], $urandom, 0, $urandom, 0, 0);
      else if (kind == 2) t = mk(0, 1, 3'($urandom_range(0, 2)), $urandom, $urandom, 0, 0, 0);
      else                t = mk(0, 0, 3'($urandom_range(0, 7)), $urandom, $urandom, 0, 0, 0);
      size = t.f3[1] ? 4 : (t.f3[0] ? 2 : 1);
      if ($urandom_range(0, 3) != 0) t.addr = t.addr - (t.addr % size);
      t.ctrl = 6'($urandom);
      t.ill = ($urandom_range(0, 9) == 0);
      t.iam = ($urandom_range(0, 9) == 0);
      t.flush_idle = ($urandom_range(0, 11) == 0);
      t.flush_mid = ($urandom_range(0, 7) == 0);
      t.waits = $urandom_range(0, 3);
      t.err = ($urandom_range(0, 5) == 0);
      t.both = $urandom_range(0, 1);
      send(t);
      repeat ($urandom_range(0, 2)) begin @(posedge clk); #1; end
    end

    repeat (5) @(posedge clk);
    #1;
    check("queue_empty", exp_q.size(), 0);
    finish_up();
  end

endmodule
